// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer.
//   ADDR_W / INSTR_W : PC and instruction widths
//   PC_STEP          : byte increment between sequential instructions
//   RESET_PC         : PC value forced while rst is high
//   NOP_INSTR        : value held in the IF/ID slot out of reset
//   fetch_state_e    : fetch FSM encoding (exposed on the debug port)
package fetch_sequencer_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0]  PC_STEP   = 16'd2;
  localparam logic [ADDR_W-1:0]  RESET_PC  = 16'h0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  // Instructions are halfword aligned; a redirect target's bit0 is dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Signal bundle between the fetch sequencer and its surroundings
// (PC register, instruction memory, decode stage, branch unit).
//   master : fetch sequencer side
//   slave  : environment side (PC register, memory, decode, branch unit)
//
// Handshake rules:
//   imem_req/imem_ack : imem_req is held high until an imem_ack arrives;
//     imem_ack may only be asserted while imem_req is high, and imem_rdata
//     is valid in the ack cycle for the address on imem_addr in that cycle.
//   if_valid/stall    : the IF/ID slot is consumed in a cycle where
//     if_valid=1 and stall=0; while stall=1 the slot is held unchanged.
//   redirect_valid    : single-cycle, no back-pressure; always taken.
interface fetch_sequencer_if;
  import fetch_sequencer_pkg::*;

  logic [ADDR_W-1:0]  pc_output;
  logic [ADDR_W-1:0]  pc_input;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_target;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;

  modport master (
    input  pc_output, imem_ack, imem_rdata, stall, redirect_valid, redirect_target,
    output pc_input, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output pc_output, imem_ack, imem_rdata, stall, redirect_valid, redirect_target,
    input  pc_input, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

endinterface

// File: rtl/fetch_sequencer_pc_next_mux.sv
// Next-PC selection for the external PC register.
//   rst             : forces RESET_PC
//   redirect_valid  : selects the aligned redirect_target
//   advance         : an instruction was accepted; step sequentially
//   pc_output       : current PC
//   redirect_target : branch/jump destination
//   pc_input        : PC to be loaded at the next clock edge
module fetch_sequencer_pc_next_mux
  import fetch_sequencer_pkg::*;
(
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic              advance,
  input  logic [ADDR_W-1:0] pc_output,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic [ADDR_W-1:0] pc_input
);

  always_comb begin
    pc_input = pc_output;
    if (rst) begin
      pc_input = RESET_PC;
    end else if (redirect_valid) begin
      pc_input = align_pc(redirect_target);
    end else if (advance) begin
      // Truncation to ADDR_W bits gives the wrap from the top of memory to 0.
      pc_input = pc_output + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Non-pipelined instruction fetch sequencer. Closes the loop with an
// external PC register, requests one instruction at a time from
// instruction memory and presents it in the IF/ID slot.
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : fetch_sequencer_if master (PC, imem, IF/ID, stall, redirect)
//   dbg_state : current fetch FSM state
module fetch_sequencer
  import fetch_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   bus,
  output fetch_state_e        dbg_state
);

  fetch_state_e state;
  fetch_state_e state_next;

  logic               advance;
  logic               if_valid_q;
  logic [INSTR_W-1:0] if_instr_q;
  logic [ADDR_W-1:0]  if_pc_q;

  // An instruction is accepted only from REQ; a redirect in the same
  // cycle wins and the returned data is dropped.
  assign advance = (state == REQ) && bus.imem_ack && !bus.redirect_valid;

  fetch_sequencer_pc_next_mux u_pc_next_mux (
    .rst             (rst),
    .redirect_valid  (bus.redirect_valid),
    .advance         (advance),
    .pc_output       (bus.pc_output),
    .redirect_target (bus.redirect_target),
    .pc_input        (bus.pc_input)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (bus.redirect_valid) begin
          // Without an ack the old request is still outstanding and must
          // be completed (and discarded) before fetching at the target.
          state_next = bus.imem_ack ? REQ : DRAIN;
        end else if (bus.imem_ack) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid || !bus.stall) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (!bus.redirect_valid && bus.imem_ack) begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.imem_req  = (state == REQ) || (state == DRAIN);
    bus.imem_addr = bus.pc_output;
    dbg_state     = state;
  end

  // IF/ID slot
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= '0;
    end else if (bus.redirect_valid) begin
      if_valid_q <= 1'b0;
    end else if (advance) begin
      if_valid_q <= 1'b1;
      if_instr_q <= bus.imem_rdata;
      if_pc_q    <= bus.pc_output;
    end else if ((state == HOLD) && !bus.stall) begin
      if_valid_q <= 1'b0;
    end
  end

  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc    = if_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model of the fetch loop.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_sequencer_if bus();
  fetch_state_e      dbg_state;

  fetch_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // External PC register: loads pc_input every clock.
  logic [15:0] pc_reg = 16'h0000;
  always @(posedge clk) pc_reg <= bus.pc_input;
  assign bus.pc_output = pc_reg;

  // Memory contents: a fixed scramble of the address.
  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    logic [15:0] p;
    p = addr * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic a, input logic s,
                     input logic rv, input logic [15:0] t);
    @(posedge clk);
    #1;
    rst                 = r;
    bus.imem_ack        = a;
    bus.imem_rdata      = a ? mem_word(pc_reg) : 16'($urandom);
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = t;
  endtask

  // ---------------- behavioural model ----------------
  // Flags describing the fetch loop: a request is outstanding (m_req),
  // its data is to be thrown away (m_stale), and the IF/ID slot content.
  logic        chk_on  = 1'b0;
  logic        m_req   = 1'b0;
  logic        m_stale = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_instr = 16'h0;
  logic [15:0] m_ipc   = 16'h0;
  logic [15:0] m_pc    = 16'h0;

  function automatic logic [15:0] model_next_pc();
    logic [15:0] t;
    if (rst) return 16'h0000;
    if (bus.redirect_valid) begin
      t = bus.redirect_target;
      t[0] = 1'b0;
      return t;
    end
    if (m_req && !m_stale && bus.imem_ack) return 16'(m_pc + 16'd2);
    return m_pc;
  endfunction

  always @(posedge clk) begin
    logic [15:0] nxt;
    if (rst) begin
      m_req = 0; m_stale = 0; m_valid = 0; m_instr = 0; m_ipc = 0; m_pc = 0;
      chk_on = 1'b1;
    end else begin
      nxt = model_next_pc();
      if (bus.redirect_valid) begin
        m_valid = 0;
        if (m_stale)     m_stale = 1;              // keep draining
        else if (m_req)  m_stale = !bus.imem_ack;  // outstanding request left behind
        else             m_stale = 0;
        m_req = 1;
      end else if (m_stale) begin
        if (bus.imem_ack) m_stale = 0;
      end else if (m_req) begin
        if (bus.imem_ack) begin
          m_valid = 1; m_instr = mem_word(m_pc); m_ipc = m_pc; m_req = 0;
        end
      end else if (m_valid) begin
        if (!bus.stall) begin m_valid = 0; m_req = 1; end
      end else begin
        m_req = 1;
      end
      m_pc = nxt;
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      chk("imem_req", 32'(bus.imem_req), 32'(m_req));
      if (m_req) chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("pc_input", 32'(bus.pc_input), 32'(model_next_pc()));
      chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
      if (m_valid) begin
        chk("if_instr", 32'(bus.if_instr), 32'(m_instr));
        chk("if_pc", 32'(bus.if_pc), 32'(m_ipc));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.imem_ack = 0; bus.imem_rdata = 0; bus.stall = 0;
    bus.redirect_valid = 0; bus.redirect_target = 0;

    // Reset held for 5 clocks
    repeat (5) cyc(1, 0, 0, 0, 16'h0);
    @(negedge clk);
    chk("rst_pc_input", 32'(bus.pc_input), 32'h0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'h0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'h0);
    chk("rst_if_instr", 32'(bus.if_instr), 32'h0);
    chk("rst_if_pc",    32'(bus.if_pc),    32'h0);
    chk("rst_state",    32'(dbg_state),    32'd0);

    // Sequential fetch, ack one cycle late
    cyc(0, 0, 0, 0, 16'h0); @(negedge clk);
    chk("idle_req", 32'(bus.imem_req), 32'h0);
    cyc(0, 0, 0, 0, 16'h0); @(negedge clk);
    chk("req0_req", 32'(bus.imem_req), 32'h1);
    chk("req0_addr", 32'(bus.imem_addr), 32'h0);
    cyc(0, 1, 0, 0, 16'h0); @(negedge clk);
    chk("ack0_pc_input", 32'(bus.pc_input), 32'h2);
    cyc(0, 0, 0, 0, 16'h0); @(negedge clk);
    chk("hold0_if_pc", 32'(bus.if_pc), 32'h0);
    chk("hold0_if_instr", 32'(bus.if_instr), 32'(mem_word(16'h0)));
    chk("hold0_req", 32'(bus.imem_req), 32'h0);
    cyc(0, 0, 0, 0, 16'h0);
    cyc(0, 1, 0, 0, 16'h0); @(negedge clk);
    chk("ack2_pc_input", 32'(bus.pc_input), 32'h4);

    // Stall for 4 cycles on the instruction from address 2
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 16'h0); @(negedge clk);
      chk("stall_if_pc", 32'(bus.if_pc), 32'h2);
      chk("stall_if_valid", 32'(bus.if_valid), 32'h1);
      chk("stall_req", 32'(bus.imem_req), 32'h0);
      chk("stall_pc_input", 32'(bus.pc_input), 32'h4);
    end
    cyc(0, 0, 0, 0, 16'h0);
    cyc(0, 1, 0, 0, 16'h0); @(negedge clk);
    chk("req4_addr", 32'(bus.imem_addr), 32'h4);
    chk("ack4_pc_input", 32'(bus.pc_input), 32'h6);
    cyc(0, 0, 0, 0, 16'h0);

    // Redirect while the request at 6 is pending
    cyc(0, 0, 0, 1, 16'h0041); @(negedge clk);
    chk("redir_addr_before", 32'(bus.imem_addr), 32'h6);
    chk("redir_pc_input", 32'(bus.pc_input), 32'h0040);
    cyc(0, 1, 0, 0, 16'h0); @(negedge clk);
    chk("drain_state", 32'(dbg_state), 32'd3);
    chk("drain_if_valid", 32'(bus.if_valid), 32'h0);
    chk("drain_req", 32'(bus.imem_req), 32'h1);
    chk("drain_pc_input", 32'(bus.pc_input), 32'h0040);
    cyc(0, 1, 0, 0, 16'h0); @(negedge clk);
    chk("tgt_pc_input", 32'(bus.pc_input), 32'h0042);
    cyc(0, 0, 0, 1, 16'hFFFF); @(negedge clk);
    chk("tgt_if_pc", 32'(bus.if_pc), 32'h0040);
    chk("tgt_if_valid", 32'(bus.if_valid), 32'h1);
    chk("redir2_pc_input", 32'(bus.pc_input), 32'hFFFE);

    // Wrap at the top of the address space
    cyc(0, 1, 0, 0, 16'h0); @(negedge clk);
    chk("wrap_addr", 32'(bus.imem_addr), 32'hFFFE);
    chk("wrap_pc_input", 32'(bus.pc_input), 32'h0000);
    cyc(0, 0, 0, 0, 16'h0); @(negedge clk);
    chk("wrap_if_pc", 32'(bus.if_pc), 32'hFFFE);
    cyc(0, 0, 0, 0, 16'h0); @(negedge clk);
    chk("wrap_next_addr", 32'(bus.imem_addr), 32'h0);
    chk("wrap_next_req", 32'(bus.imem_req), 32'h1);

    // Reset while a request is outstanding, acks during reset ignored
    cyc(1, 1, 0, 0, 16'h0); @(negedge clk);
    chk("rstmid_pc_input", 32'(bus.pc_input), 32'h0);
    cyc(1, 1, 0, 0, 16'h0); @(negedge clk);
    chk("rstmid_req", 32'(bus.imem_req), 32'h0);
    chk("rstmid_if_valid", 32'(bus.if_valid), 32'h0);
    cyc(0, 0, 0, 0, 16'h0);
    cyc(0, 0, 0, 0, 16'h0); @(negedge clk);
    chk("restart_req", 32'(bus.imem_req), 32'h1);
    chk("restart_addr", 32'(bus.imem_addr), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic        r, a, s, rv;
      logic [15:0] t;
      r  = ($urandom_range(0, 99) == 0);
      a  = bus.imem_req && ($urandom_range(0, 2) != 0);
      s  = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 7) == 0);
      t  = ($urandom_range(0, 3) == 0) ? (16'hFFFE | 16'($urandom_range(0, 1)))
                                       : 16'($urandom);
      cyc(r, a, s, rv, t);
    end
    cyc(0, 0, 0, 0, 16'h0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
